// File: rtl/montgomery_param.sv
// Radix-2 bit-serial Montgomery multiplier with a parametrised width.
// Computes result = a * b * 2^-WIDTH mod m, one bit of a per clock.
module montgomery_param #(
  parameter int WIDTH = 512,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = WIDTH + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOOP = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    c_q;
  logic [CNT_W-1:0] i_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;

  logic [CW-1:0]    b_add;
  logic [CW-1:0]    t;
  logic [CW-1:0]    m_add;
  logic [CW-1:0]    c_nxt;
  logic [CW-1:0]    m_ext;
  logic             c_ge_m;
  logic [WIDTH-1:0] c_red;
  logic             last;

  // One Montgomery iteration and the final conditional subtraction.
  // a_q is shifted right each step, so a_q[0] is the current bit.
  always_comb begin
    m_ext  = {2'b00, m_q};
    b_add  = a_q[0] ? {2'b00, b_q} : '0;
    t      = c_q + b_add;
    m_add  = t[0] ? m_ext : '0;
    c_nxt  = (t + m_add) >> 1;
    c_ge_m = (c_q >= m_ext);
    c_red  = c_ge_m ? (c_q[WIDTH-1:0] - m_q)
                    : c_q[WIDTH-1:0];
    last   = (i_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM plus operand, accumulator and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      c_q    <= '0;
      i_q    <= '0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            c_q   <= '0;
            i_q   <= '0;
            state <= S_LOOP;
          end
        end
        S_LOOP: begin
          c_q <= c_nxt;
          a_q <= a_q >> 1;
          i_q <= i_q + CNT_W'(1);
          if (last)
            state <= S_SUB;
        end
        S_SUB: begin
          res_q  <= c_red;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state == S_LOOP) ||
                  (state == S_SUB);
  assign done   = done_q;
  assign result = res_q;

endmodule

// File: tb/tb_montgomery_param.sv
// Randomised self-checking bench for montgomery_param.
// Covers WIDTH=8 directed cases and WIDTH=512 random vectors.
module tb_montgomery_param;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  logic       s8;
  logic [7:0] a8, b8, m8;
  logic       busy8, done8;
  logic [7:0] r8;

  logic         s5;
  logic [511:0] a5, b5, m5;
  logic         busy5, done5;
  logic [511:0] r5;

  montgomery_param #(.WIDTH(8)) u8 (
    .clk(clk), .resetn(resetn), .start(s8),
    .in_a(a8), .in_b(b8), .in_m(m8),
    .busy(busy8), .done(done8), .result(r8)
  );

  montgomery_param #(.WIDTH(512)) u512 (
    .clk(clk), .resetn(resetn), .start(s5),
    .in_a(a5), .in_b(b5), .in_m(m5),
    .busy(busy5), .done(done5), .result(r5)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag,
                       input logic [511:0] got,
                       input logic [511:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // a*b mod m, then halved mod m n times (m odd).
  function automatic logic [511:0] mont_ref(
    input logic [511:0] a, b, m, input int n);
    logic [1025:0] p, mm;
    mm = {514'b0, m};
    p  = ({514'b0, a} * {514'b0, b}) % mm;
    for (int k = 0; k < n; k++)
      p = p[0] ? (p + mm) >> 1 : p >> 1;
    return p[511:0];
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      r = {r[479:0], 32'($urandom())};
    return r;
  endfunction

  task automatic op8(input logic [7:0] a, b, m,
                     input bit chk_res, input bit poke);
    int cyc, nbusy, extra;
    logic [511:0] tmp;
    logic [7:0] expv;
    tmp  = mont_ref({504'b0, a}, {504'b0, b},
                    {504'b0, m}, 8);
    expv = tmp[7:0];
    @(negedge clk);
    a8 = a; b8 = b; m8 = m; s8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s8 = 1'b0;
    a8 = 8'($urandom());
    b8 = 8'($urandom());
    m8 = 8'($urandom());
    cyc = 0; nbusy = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) nbusy++;
      if (poke && cyc == 3) begin
        s8 = 1'b1; a8 = 8'd1;
        b8 = 8'($urandom()); m8 = 8'($urandom());
      end else s8 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    s8 = 1'b0;
    check("lat8", cyc, 9);
    check("busy_cycles8", nbusy, 9);
    check("busy_at_done8", {511'b0, busy8}, 0);
    if (chk_res) check("res8", {504'b0, r8}, expv);
    @(negedge clk);
    check("done_pulse8", {511'b0, done8}, 0);
    if (poke) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (done8 || busy8) extra++;
      end
      check("ignored_start8", extra, 0);
    end
  endtask

  task automatic op512(input logic [511:0] a, b, m);
    int cyc;
    logic [511:0] expv;
    expv = mont_ref(a, b, m, 512);
    @(negedge clk);
    a5 = a; b5 = b; m5 = m; s5 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s5 = 1'b0;
    a5 = rnd512(); b5 = rnd512(); m5 = rnd512();
    cyc = 0;
    while (!done5 && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    check("lat512", cyc, 513);
    check("res512", r5, expv);
    @(negedge clk);
  endtask

  initial begin
    int times[$];
    int cyc, pulses;
    logic [511:0] va, vb, vm;
    s8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
    s5 = 1'b0; a5 = '0; b5 = '0; m5 = '0;
    #1;
    check("rst_busy8", {511'b0, busy8}, 0);
    check("rst_done8", {511'b0, done8}, 0);
    check("rst_res8", {504'b0, r8}, 0);
    check("rst_res512", r5, 0);
    #20;
    @(negedge clk);
    resetn = 1'b1;

    op8(8'd5, 8'd7, 8'd13, 1'b1, 1'b0);
    check("res8_5x7", {504'b0, r8}, 1);
    op8(8'd13, 8'd5, 8'd13, 1'b1, 1'b0);
    check("res8_cm", {504'b0, r8}, 0);
    op8(8'd0, 8'd12, 8'd13, 1'b1, 1'b0);
    op8(8'd200, 8'd0, 8'd13, 1'b1, 1'b0);
    op8(8'd5, 8'd7, 8'd12, 1'b0, 1'b0);
    op8(8'd9, 8'd200, 8'd13, 1'b0, 1'b0);
    op8(8'd5, 8'd7, 8'd13, 1'b1, 1'b1);
    check("res8_poke", {504'b0, r8}, 1);
    for (int k = 0; k < 10; k++) begin
      vm = {504'b0, 8'($urandom()) | 8'h81};
      vb = {504'b0, 8'($urandom())} % vm;
      op8(8'($urandom()), vb[7:0], vm[7:0],
          1'b1, 1'b0);
    end

    @(negedge clk);
    a8 = 8'd1; b8 = 8'd1; m8 = 8'd13; s8 = 1'b1;
    cyc = 0;
    while (times.size() < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        times.push_back(cyc);
        check("hold_res8", {504'b0, r8}, 3);
        if (times.size() == 3) s8 = 1'b0;
      end
    end
    s8 = 1'b0;
    pulses = times.size();
    check("hold_pulses8", pulses, 3);
    if (pulses == 3) begin
      check("hold_gap8a", times[1] - times[0], 11);
      check("hold_gap8b", times[2] - times[1], 11);
    end
    repeat (3) @(negedge clk);

    @(negedge clk);
    a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; s8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_busy8", {511'b0, busy8}, 0);
    check("arst_done8", {511'b0, done8}, 0);
    check("arst_res8", {504'b0, r8}, 0);
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 || busy8) pulses++;
    end
    check("arst_quiet8", pulses, 0);
    op8(8'd5, 8'd7, 8'd13, 1'b1, 1'b0);
    check("arst_redo8", {504'b0, r8}, 1);

    vm = rnd512(); vm[0] = 1'b1;
    op512('0, rnd512() % vm, vm);
    check("res512_a0", r5, 0);
    op512(rnd512(), '0, vm);
    for (int k = 0; k < 100; k++) begin
      vm = rnd512(); vm[0] = 1'b1;
      if (vm < 3) vm = 3;
      vb = rnd512() % vm;
      va = rnd512();
      op512(va, vb, vm);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
